// File: rtl/instruction_sender_pkg.sv
// Shared opcodes, frame sizes and FSM state type for the Titan SPI command sender.
package instruction_sender_pkg;

  localparam logic [7:0] OpNop      = 8'h00;
  localparam logic [7:0] OpWrite    = 8'h01;
  localparam logic [7:0] OpRead     = 8'h02;
  localparam logic [7:0] OpStream   = 8'h03;
  localparam logic [7:0] OpTransfer = 8'h04;
  localparam logic [7:0] OpRepeat   = 8'h05;

  localparam int unsigned WriteFrameBytes   = 8;
  localparam int unsigned ReadFrameBytes    = 4;
  localparam int unsigned ReadbackExchanges = 6;

  typedef enum logic [2:0] {
    StIdle,
    StSend,
    StWaitRx,
    StTurnaround,
    StRdseq,
    StFinish
  } sender_state_e;

  // REPEAT, four TRANSFERs, then a NOP to clock out the last data byte.
  function automatic logic [63:0] readback_seq();
    return {OpRepeat, OpTransfer, OpTransfer, OpTransfer, OpTransfer, OpNop, 16'h0000};
  endfunction

endpackage

// File: rtl/instruction_sender_if.sv
// Byte-level link between the command sender and the SPI master byte engine.
interface instruction_sender_if;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_byte;
  logic       rx_valid;

  modport master (output tx_byte, tx_valid, input tx_ready, rx_byte, rx_valid);
  modport slave  (input tx_byte, tx_valid, output tx_ready, rx_byte, rx_valid);
endinterface

// File: rtl/comms_frame_shifter.sv
// 64-bit frame register: load, shift left by one byte, present the top byte with index/last flag.
module comms_frame_shifter (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [63:0] data_i,
  input  logic [2:0]  last_idx_i,
  input  logic        shift_i,
  output logic [7:0]  byte_o,
  output logic [2:0]  idx_o,
  output logic        last_o
);
  logic [63:0] data_q;
  logic [2:0]  cnt_q;
  logic [2:0]  last_idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q     <= '0;
      cnt_q      <= '0;
      last_idx_q <= '0;
    end else if (load_i) begin
      data_q     <= data_i;
      cnt_q      <= '0;
      last_idx_q <= last_idx_i;
    end else if (shift_i) begin
      data_q <= {data_q[55:0], 8'h00};
      cnt_q  <= cnt_q + 3'd1;
    end
  end

  assign byte_o = data_q[63:56];
  assign idx_o  = cnt_q;
  assign last_o = (cnt_q == last_idx_q);
endmodule

// File: rtl/instruction_sender.sv
// Titan SPI command initiator: serializes WRITE/READ frames and runs the READ readback sequence.
// Optional WAIT_RX watchdog enabled by defining TITAN_SENDER_TIMEOUT_EN.
module instruction_sender
  import instruction_sender_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH     = 24,
  parameter int unsigned VALUE_WIDTH       = 32,
  parameter int unsigned TURNAROUND_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES    = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [7:0]               cmd_instruction_i,
  input  logic [ADDRESS_WIDTH-1:0] cmd_address_i,
  input  logic [VALUE_WIDTH-1:0]   cmd_value_i,
  output logic                     rsp_valid_o,
  output logic [VALUE_WIDTH-1:0]   rsp_value_o,
  output logic                     cmd_done_o,
  output logic                     cmd_error_o,
  instruction_sender_if.master     spi
);
  localparam int unsigned TurnW = (TURNAROUND_CYCLES > 1) ? $clog2(TURNAROUND_CYCLES) : 1;
  localparam int unsigned AccW  = VALUE_WIDTH - 8;

  if (ADDRESS_WIDTH != 24 || VALUE_WIDTH != 32 || TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("instruction_sender: needs ADDRESS_WIDTH=24, VALUE_WIDTH=32, TIMEOUT_CYCLES>0");
  end

  sender_state_e          state_q, state_d;
  logic                   is_read_q, is_read_d;
  logic                   rd_phase_q, rd_phase_d;
  logic                   cmd_error_q, cmd_error_d;
  logic [TurnW-1:0]       turn_cnt_q, turn_cnt_d;
  logic [AccW-1:0]        acc_q, acc_d;
  logic [VALUE_WIDTH-1:0] rsp_value_q, rsp_value_d;

  logic        fs_load, fs_shift, fs_last;
  logic [63:0] fs_data;
  logic [2:0]  fs_last_idx, fs_idx;
  logic [7:0]  fs_byte;
  logic        tx_valid;
  logic        tmo_hit;

  comms_frame_shifter u_shifter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (fs_load),
    .data_i     (fs_data),
    .last_idx_i (fs_last_idx),
    .shift_i    (fs_shift),
    .byte_o     (fs_byte),
    .idx_o      (fs_idx),
    .last_o     (fs_last)
  );

`ifdef TITAN_SENDER_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == StWaitRx && !spi.rx_valid) tmo_cnt_d = tmo_cnt_q + TmoW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_cnt_q <= '0;
    else     tmo_cnt_q <= tmo_cnt_d;
  end

  assign tmo_hit = (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    is_read_d   = is_read_q;
    rd_phase_d  = rd_phase_q;
    cmd_error_d = 1'b0;
    turn_cnt_d  = turn_cnt_q;
    acc_d       = acc_q;
    rsp_value_d = rsp_value_q;
    fs_load     = 1'b0;
    fs_shift    = 1'b0;
    fs_data     = {cmd_instruction_i, cmd_address_i, cmd_value_i};
    fs_last_idx = 3'(WriteFrameBytes - 1);

    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          if (cmd_instruction_i == OpWrite || cmd_instruction_i == OpRead) begin
            fs_load    = 1'b1;
            is_read_d  = (cmd_instruction_i == OpRead);
            rd_phase_d = 1'b0;
            state_d    = StSend;
            if (cmd_instruction_i == OpRead) fs_last_idx = 3'(ReadFrameBytes - 1);
          end else begin
            cmd_error_d = 1'b1;
          end
        end
      end
      StSend, StRdseq: begin
        if (spi.tx_ready) state_d = StWaitRx;
      end
      StWaitRx: begin
        if (spi.rx_valid) begin
          // E0/E1 answer the REPEAT/first TRANSFER and carry no data.
          if (rd_phase_q && fs_idx >= 3'd2) acc_d = {acc_q[AccW-9:0], spi.rx_byte};
          if (!fs_last) begin
            fs_shift = 1'b1;
            state_d  = rd_phase_q ? StRdseq : StSend;
          end else if (rd_phase_q) begin
            rsp_value_d = {acc_q, spi.rx_byte};
            state_d     = StFinish;
          end else if (is_read_q) begin
            fs_load     = 1'b1;
            fs_data     = readback_seq();
            fs_last_idx = 3'(ReadbackExchanges - 1);
            rd_phase_d  = 1'b1;
            turn_cnt_d  = '0;
            state_d     = (TURNAROUND_CYCLES == 0) ? StRdseq : StTurnaround;
          end else begin
            state_d = StFinish;
          end
        end else if (tmo_hit) begin
          cmd_error_d = 1'b1;
          state_d     = StIdle;
        end
      end
      StTurnaround: begin
        if (turn_cnt_q == TurnW'(TURNAROUND_CYCLES - 1)) state_d = StRdseq;
        else turn_cnt_d = turn_cnt_q + TurnW'(1);
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      is_read_q   <= 1'b0;
      rd_phase_q  <= 1'b0;
      cmd_error_q <= 1'b0;
      turn_cnt_q  <= '0;
      acc_q       <= '0;
      rsp_value_q <= '0;
    end else begin
      state_q     <= state_d;
      is_read_q   <= is_read_d;
      rd_phase_q  <= rd_phase_d;
      cmd_error_q <= cmd_error_d;
      turn_cnt_q  <= turn_cnt_d;
      acc_q       <= acc_d;
      rsp_value_q <= rsp_value_d;
    end
  end

  assign tx_valid     = (state_q == StSend) || (state_q == StRdseq);
  assign spi.tx_valid = tx_valid;
  assign spi.tx_byte  = tx_valid ? fs_byte : 8'h00;
  assign cmd_ready_o  = (state_q == StIdle);
  assign cmd_done_o   = (state_q == StFinish);
  assign rsp_valid_o  = (state_q == StFinish) && is_read_q;
  assign rsp_value_o  = rsp_value_q;
  assign cmd_error_o  = cmd_error_q;
endmodule

// File: doc/instruction_sender.md
Name: instruction_sender

Overview:
- Host-side initiator for the Titan SPI command protocol; the counterpart of the target-side instruction decoder.
- Accepts one command (opcode, address, value) per handshake and serializes it MSB-first into bytes for an SPI master byte engine.
- For READ, it drives the REPEAT/TRANSFER readback sequence and reassembles the 32-bit result.
- Sits between host control logic and the SPI master.

Parameters:
- ADDRESS_WIDTH, 24, address field width; must be 24 (3 bytes on the wire).
- VALUE_WIDTH, 32, value field width; must be 32 (4 bytes on the wire).
- TURNAROUND_CYCLES, 4, idle clocks between last READ frame byte and REPEAT, giving the core time to produce data.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with TITAN_SENDER_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_instruction  in  8  opcode (TitanComms values).
- cmd_address  in  ADDRESS_WIDTH  target address.
- cmd_value  in  VALUE_WIDTH  write data (ignored for READ).
- rsp_valid  out  1  one-cycle pulse; read data valid.
- rsp_value  out  VALUE_WIDTH  reassembled read data; held until next rsp_valid.
- cmd_done  out  1  one-cycle pulse at command completion (WRITE or READ).
- cmd_error  out  1  one-cycle pulse on rejected opcode or timeout.
- spi_tx_byte  out  8  byte to shift out.
- spi_tx_valid  out  1  byte offered to master.
- spi_tx_ready  in  1  master accepts byte when valid&ready.
- spi_rx_byte  in  8  byte received during completed exchange.
- spi_rx_valid  in  1  one-cycle pulse per completed exchange.

Behaviour:
- Reset (async, any state): state=IDLE; cmd_ready=1; spi_tx_valid=0; spi_tx_byte=0; rsp_valid=0; rsp_value=0; cmd_done=0; cmd_error=0; counters=0. An in-flight frame is abandoned and no partial response is emitted.
- Command acceptance: on cmd_valid&cmd_ready, the command is latched.
  - WRITE(1): 8-byte frame {opcode, addr[23:0], value[31:0]}, MSB first.
  - READ(2): 4-byte frame {opcode, addr[23:0]}.
  - Any other opcode (including STREAM, TRANSFER, REPEAT, NOP): cmd_error pulses the next cycle, no bytes are sent, and the block stays IDLE.
- States:
  - IDLE: waits for a command.
  - SEND: spi_tx_valid=1 with the current frame byte until accepted.
  - WAIT_RX: waits for spi_rx_valid.
  - TURNAROUND: counts TURNAROUND_CYCLES.
  - RDSEQ: drives the readback byte sequence.
  - FINISH: pulses outputs and returns to IDLE.
- One byte outstanding rule: after tx handshake, enter WAIT_RX; the next byte is never offered before spi_rx_valid. spi_tx_byte is stable while spi_tx_valid=1.
- spi_rx_valid arriving outside WAIT_RX is ignored.
- WRITE path: SEND/WAIT_RX ×8 -> FINISH. cmd_done pulses 1 cycle after the 8th spi_rx_valid.
- READ path:
  - SEND/WAIT_RX ×4 -> TURNAROUND (exactly TURNAROUND_CYCLES clocks, 0 allowed -> skip).
  - RDSEQ exchanges E0..E5: E0=REPEAT(5), E1..E4=TRANSFER(4), E5=NOP(0x00).
  - Bytes received on E2..E5 shift into rsp_value, MSB first; E0/E1 rx bytes are discarded.
  - After E5 rx: rsp_value updated, rsp_valid and cmd_done pulse together in the same cycle.
- Latency with ideal master (ready=1, rx_valid 1 cycle after accept): WRITE done 16 cycles after accept+1. READ is 8 + TURNAROUND_CYCLES + 12 cycles + 1.
- Simultaneous cmd_valid in the FINISH cycle: not accepted (cmd_ready=0); accepted the following cycle.
- Byte counter is 3 bits and wraps only via explicit reset to 0 at frame start.

Optional Feature:
- Macro TITAN_SENDER_TIMEOUT_EN.
- Defined: a counter runs in WAIT_RX. Reaching TIMEOUT_CYCLES without spi_rx_valid forces IDLE, pulses cmd_error, drops spi_tx_valid, and emits no rsp_valid or cmd_done. The counter clears on every spi_rx_valid.
- Undefined: WAIT_RX waits indefinitely; the counter and TIMEOUT_CYCLES logic are absent.

Decomposition:
- TitanComms package:
  - Opcode constants NOP=0, WRITE=1, READ=2, STREAM=3, TRANSFER=4, REPEAT=5.
  - WRITE_FRAME_BYTES=8, READ_FRAME_BYTES=4, READBACK_EXCHANGES=6.
  - The sender state enum typedef.
- One sub-module: comms_frame_shifter. It is a 64-bit load/shift-left-by-8 register presenting the top byte, with a byte counter and last flag. It is reused for both frame types.

Test Plan:
- WRITE addr=0x000010 value=0xDEADBEEF, ideal master -> tx bytes 01 00 00 10 DE AD BE EF; cmd_done pulses once; no rsp_valid.
- READ addr=0x000123, rx bytes on E2..E5 = 12 34 56 78 -> tx 02 00 01 23, gap of 4 cycles, then 05 04 04 04 04 00; rsp_value=0x12345678 with rsp_valid and cmd_done pulsed together.
- Back-pressure: spi_tx_ready low for 5 cycles during WRITE byte 3 -> spi_tx_byte held at 0x00 and valid held; frame content unchanged.
- Illegal opcode 0x03 -> cmd_error pulse; zero tx handshakes; cmd_ready high the next cycle.
- rst asserted mid-READ at E3 -> all outputs at reset values immediately; a subsequent WRITE completes correctly.
- With TITAN_SENDER_TIMEOUT_EN and TIMEOUT_CYCLES=16, withhold spi_rx_valid after byte 1 -> cmd_error at cycle 16 of wait, state IDLE, no cmd_done.
